// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file plus busy/ROB-tag rename scoreboard.
// Optional RF_CMT_BYPASS_EN: same-cycle commit data bypassed onto matching source reads.
module rename_regfile #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ROB_AW   = 4,
    parameter int ISSUE_W  = 1,
    parameter int COMMIT_W = 1,
    localparam int RA      = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic [2*ISSUE_W*RA-1:0]      rs_addr,
    output logic [2*ISSUE_W*XLEN-1:0]    rs_data,
    output logic [2*ISSUE_W-1:0]         rs_busy,
    output logic [2*ISSUE_W*ROB_AW-1:0]  rs_tag,
    input  logic [ISSUE_W-1:0]           iss_valid,
    input  logic [ISSUE_W*RA-1:0]        iss_rd,
    input  logic [ISSUE_W*ROB_AW-1:0]    iss_tag,
    input  logic [COMMIT_W-1:0]          cmt_valid,
    input  logic [COMMIT_W*RA-1:0]       cmt_rd,
    input  logic [COMMIT_W*ROB_AW-1:0]   cmt_tag,
    input  logic [COMMIT_W*XLEN-1:0]     cmt_data
);
    logic [XLEN-1:0]   data_q [NREG];
    logic [XLEN-1:0]   data_d [NREG];
    logic [ROB_AW-1:0] tag_q  [NREG];
    logic [ROB_AW-1:0] tag_d  [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [RA-1:0]     wa, ra;
    logic [XLEN-1:0]   rd_d;
    logic              rd_b;
    logic [ROB_AW-1:0] rd_t;

    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        wa     = '0;
        // Commits still land during a flush; busy clears only for the rename that is retiring.
        if (rdy || flush)
            for (int p = 0; p < COMMIT_W; p++) begin
                wa = cmt_rd[p*RA +: RA];
                if (cmt_valid[p] && wa != '0) begin
                    data_d[wa] = cmt_data[p*XLEN +: XLEN];
                    if (tag_q[wa] == cmt_tag[p*ROB_AW +: ROB_AW]) busy_d[wa] = 1'b0;
                end
            end
        if (flush)
            busy_d = '0;
        else if (rdy)
            for (int s = 0; s < ISSUE_W; s++) begin
                wa = iss_rd[s*RA +: RA];
                if (iss_valid[s] && wa != '0) begin
                    busy_d[wa] = 1'b1;
                    tag_d[wa]  = iss_tag[s*ROB_AW +: ROB_AW];
                end
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        rs_tag  = '0;
        ra      = '0;
        rd_d    = '0;
        rd_b    = 1'b0;
        rd_t    = '0;
        for (int i = 0; i < 2*ISSUE_W; i++) begin
            ra   = rs_addr[i*RA +: RA];
            rd_d = data_q[ra];
            rd_b = busy_q[ra];
            rd_t = tag_q[ra];
`ifdef RF_CMT_BYPASS_EN
            for (int p = 0; p < COMMIT_W; p++)
                if (rdy && cmt_valid[p] && cmt_rd[p*RA +: RA] == ra && ra != '0 && busy_q[ra] &&
                    tag_q[ra] == cmt_tag[p*ROB_AW +: ROB_AW]) begin
                    rd_d = cmt_data[p*XLEN +: XLEN];
                    rd_b = 1'b0;
                end
`endif
            // Older slots in the same group win over stored and committed state.
            for (int j = 0; j < i/2; j++)
                if (iss_valid[j] && iss_rd[j*RA +: RA] == ra && ra != '0) begin
                    rd_b = 1'b1;
                    rd_t = iss_tag[j*ROB_AW +: ROB_AW];
                end
            rs_data[i*XLEN +: XLEN]     = rd_d;
            rs_busy[i]                  = rd_b;
            rs_tag[i*ROB_AW +: ROB_AW]  = rd_t;
        end
    end
endmodule
